// File: rtl/sfr_arbiter_pkg.sv
// Shared types and constants for the SFR port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sfr_arb_pkg;

   // Arbiter control state: free to grant, or holding the single outstanding read.
   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_RESP = 1'b1
   } state_t;

   // Word returned to the owner when the slave never answers a read.
   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;

   // Index width that never collapses to zero bits (a 1- or 2-entry range still gets 1 bit).
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sfr_arbiter_if.sv
// Bundle of the master-side request/response lanes and the single SFR slave port.
// Latency: n/a (wires only).
// Backpressure: masters hold a request until m_ack; the slave throttles via s_ack.
// Ports: m_req/m_we/m_addr/m_be/m_wdata (packed, master i at slice i), m_ack/m_resp one bit
// per master, m_rdata shared; s_req/s_we/s_addr/s_be/s_wdata towards the slave,
// s_ack/s_resp/s_rdata back from it.
interface sfr_arbiter_if #(
   parameter int NUM_M = 2
);
   logic [NUM_M-1:0]    m_req;
   logic [NUM_M-1:0]    m_we;
   logic [NUM_M*32-1:0] m_addr;
   logic [NUM_M*4-1:0]  m_be;
   logic [NUM_M*32-1:0] m_wdata;
   logic [NUM_M-1:0]    m_ack;
   logic [NUM_M-1:0]    m_resp;
   logic [31:0]         m_rdata;

   logic                s_req;
   logic                s_we;
   logic [31:0]         s_addr;
   logic [3:0]          s_be;
   logic [31:0]         s_wdata;
   logic                s_ack;
   logic                s_resp;
   logic [31:0]         s_rdata;

   // Arbiter view: consumes master requests and slave replies, drives the rest.
   modport slave (
      input  m_req, m_we, m_addr, m_be, m_wdata,
      output m_ack, m_resp, m_rdata,
      output s_req, s_we, s_addr, s_be, s_wdata,
      input  s_ack, s_resp, s_rdata
   );

   // Environment view: the requesting masters together with the SFR slave.
   modport master (
      output m_req, m_we, m_addr, m_be, m_wdata,
      input  m_ack, m_resp, m_rdata,
      input  s_req, s_we, s_addr, s_be, s_wdata,
      output s_ack, s_resp, s_rdata
   );

endinterface

// File: rtl/sfr_arbiter_rr_pick.sv
// Picks one requester: first set bit at or above ptr_i, wrapping; lowest index when fixed_i.
// Latency: purely combinational.
// Backpressure: none; grant is recomputed every cycle from req_i.
// Ports: req_i request vector, ptr_i round-robin start, fixed_i priority mode,
// grant_o one-hot grant, idx_o binary index of the grant (0 when nothing requests).
module rr_pick
   import sfr_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   input  logic          fixed_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o
);

   int   start;
   int   cand;
   logic found;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = 0;
      start   = fixed_i ? 0 : int'(ptr_i);
      // Walk the ring once starting at the pointer; the first hit wins.
      for (int k = 0; k < N; k++) begin
         cand = start + k;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (!found && req_i[cand]) begin
            found          = 1'b1;
            grant_o[cand]  = 1'b1;
            idx_o          = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/sfr_arbiter.sv
// Shares one SFR slave port between NUM_M masters, one transfer at a time, one read in flight.
// Latency: request->slave combinational; read response routed to its owner in the same cycle.
// Backpressure: s_ack stalls the grant (grant locked until accepted); no grants during a read.
// Ports: clk_i, rst_ni (async, active low), bus (sfr_arbiter_if.slave: master lanes and slave
// port), err_timeout_o one-cycle pulse on a forced timeout response, busy_o high in WAIT_RESP.
module sfr_arbiter
   import sfr_arb_pkg::*;
#(
   parameter int NUM_M        = 2,
   parameter int PRIO_FIXED   = 0,
   parameter int RESP_TIMEOUT = 255
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   sfr_arbiter_if.slave bus,
   output logic         err_timeout_o,
   output logic         busy_o
);

   localparam int            IW   = idx_w(NUM_M);
   localparam int            TW   = idx_w(RESP_TIMEOUT + 1);
   localparam logic [IW-1:0] LAST = IW'(NUM_M - 1);

   state_t             state_q, state_d;
   logic               lock_q;
   logic [IW-1:0]      locked_g_q, rr_ptr_q, owner_q;
   logic [TW-1:0]      tmo_cnt_q;

   logic [IW-1:0]      pick_idx, g, g_next;
   logic [NUM_M-1:0]   pick_oh, g_oh;
   logic               tmo_hit;

   logic               s_req, s_we;
   logic [31:0]        s_addr, s_wdata, m_rdata;
   logic [3:0]         s_be;
   logic [NUM_M-1:0]   m_ack, m_resp;
   logic               err, busy;

   rr_pick #(
      .N  (NUM_M),
      .IW (IW)
   ) u_pick (
      .req_i   (bus.m_req),
      .ptr_i   (rr_ptr_q),
      .fixed_i (PRIO_FIXED != 0),
      .grant_o (pick_oh),
      .idx_o   (pick_idx)
   );

   // A request the slave has not yet accepted keeps its grant, so the slave never sees the
   // address change under a pending request.
   assign g       = lock_q ? locked_g_q : pick_idx;
   assign g_oh    = lock_q ? (NUM_M'(1) << locked_g_q) : pick_oh;
   assign g_next  = (g == LAST) ? '0 : g + 1'b1;
   assign tmo_hit = (RESP_TIMEOUT != 0) && (tmo_cnt_q == TW'(RESP_TIMEOUT));

   always_comb begin
      state_d = state_q;
      s_req   = 1'b0;
      s_we    = 1'b0;
      s_addr  = '0;
      s_be    = '0;
      s_wdata = '0;
      m_ack   = '0;
      m_resp  = '0;
      m_rdata = bus.s_rdata;
      err     = 1'b0;
      busy    = 1'b0;
      if (!rst_ni) begin
         // The slave path is combinational, so outputs are forced low explicitly in reset.
         m_rdata = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (|bus.m_req) begin
                  s_req   = 1'b1;
                  s_we    = bus.m_we[g];
                  s_addr  = bus.m_addr[32*g +: 32];
                  s_be    = bus.m_be[4*g +: 4];
                  s_wdata = bus.m_wdata[32*g +: 32];
                  m_ack   = g_oh & {NUM_M{bus.s_ack}};
                  if (bus.s_ack && !s_we) begin
                     state_d = WAIT_RESP;
                  end
               end
            end
            WAIT_RESP: begin
               busy = 1'b1;
               // A real response beats a timeout landing in the same cycle.
               if (bus.s_resp) begin
                  m_resp[owner_q] = 1'b1;
                  state_d         = IDLE;
               end else if (tmo_hit) begin
                  m_resp[owner_q] = 1'b1;
                  m_rdata         = TIMEOUT_RDATA;
                  err             = 1'b1;
                  state_d         = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         lock_q     <= 1'b0;
         locked_g_q <= '0;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         tmo_cnt_q  <= '0;
      end else begin
         state_q <= state_d;
         if (s_req) begin
            if (bus.s_ack) begin
               lock_q   <= 1'b0;
               rr_ptr_q <= g_next;
               if (!s_we) begin
                  owner_q   <= g;
                  tmo_cnt_q <= '0;
               end
            end else begin
               lock_q     <= 1'b1;
               locked_g_q <= g;
            end
         end else if (busy && (tmo_cnt_q != '1)) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
         end
      end
   end

   assign bus.s_req     = s_req;
   assign bus.s_we      = s_we;
   assign bus.s_addr    = s_addr;
   assign bus.s_be      = s_be;
   assign bus.s_wdata   = s_wdata;
   assign bus.m_ack     = m_ack;
   assign bus.m_resp    = m_resp;
   assign bus.m_rdata   = m_rdata;
   assign err_timeout_o = err;
   assign busy_o        = busy;

endmodule

// File: tb/tb_sfr_arbiter.sv
// Bench for sfr_arbiter: directed scenarios plus a random phase checked cycle by cycle
// against a transaction-level model of the arbitration rules.
// Latency/backpressure: inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_sfr_arbiter;
   import sfr_arb_pkg::*;

   localparam int N   = 2;
   localparam int TMO = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic err_a, busy_a, err_f, busy_f;

   int tests = 0;
   int fails = 0;
   string step = "init";

   always #5 clk = ~clk;

   sfr_arbiter_if #(.NUM_M(N)) bus_a ();
   sfr_arbiter_if #(.NUM_M(N)) bus_f ();

   sfr_arbiter #(.NUM_M(N), .PRIO_FIXED(0), .RESP_TIMEOUT(TMO)) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus_a), .err_timeout_o(err_a), .busy_o(busy_a)
   );

   sfr_arbiter #(.NUM_M(N), .PRIO_FIXED(1), .RESP_TIMEOUT(255)) dut_fx (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus_f), .err_timeout_o(err_f), .busy_o(busy_f)
   );

   // Reference model: "is a read outstanding", who owns it, how long it has waited,
   // where round-robin search starts, and which master holds an unaccepted grant.
   bit md_wait, md_lock;
   int md_owner, md_ptr, md_lockg, md_cnt;

   // Expected outputs for the current cycle.
   logic           e_sreq, e_we, e_err, e_busy;
   logic [31:0]    e_addr, e_wdata, e_rdata;
   logic [3:0]     e_be;
   logic [N-1:0]   e_ack, e_resp;
   int             e_g;

   // Snapshot of DUT outputs at the sampling point, for directed constant checks.
   logic           o_sreq, o_err, o_busy;
   logic [31:0]    o_addr, o_rdata;
   logic [N-1:0]   o_ack, o_resp, o_fack;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
      end
   endtask

   task automatic set_m(input int i, input bit req, input bit we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
      bus_a.m_req[i]           = req;
      bus_a.m_we[i]            = we;
      bus_a.m_addr[32*i +: 32] = addr;
      bus_a.m_be[4*i +: 4]     = be;
      bus_a.m_wdata[32*i +: 32]= wd;
   endtask

   // One clock: predict, sample at negedge and compare, then advance the model at posedge.
   task automatic tick();
      e_sreq = 1'b0; e_we = 1'b0; e_addr = '0; e_be = '0; e_wdata = '0;
      e_ack = '0; e_resp = '0; e_rdata = bus_a.s_rdata; e_err = 1'b0; e_busy = 1'b0; e_g = 0;
      if (!rst_n) begin
         e_rdata = '0;
      end else if (!md_wait) begin
         if (bus_a.m_req != '0) begin
            e_sreq = 1'b1;
            if (md_lock) begin
               e_g = md_lockg;
            end else begin
               // Scan the ring backwards so the requester closest to md_ptr is kept last.
               for (int k = N - 1; k >= 0; k--) begin
                  if (bus_a.m_req[(md_ptr + k) % N]) e_g = (md_ptr + k) % N;
               end
            end
            e_we    = bus_a.m_we[e_g];
            e_addr  = bus_a.m_addr[32*e_g +: 32];
            e_be    = bus_a.m_be[4*e_g +: 4];
            e_wdata = bus_a.m_wdata[32*e_g +: 32];
            if (bus_a.s_ack) e_ack[e_g] = 1'b1;
         end
      end else begin
         e_busy = 1'b1;
         if (bus_a.s_resp) begin
            e_resp[md_owner] = 1'b1;
         end else if (md_cnt == TMO) begin
            e_resp[md_owner] = 1'b1;
            e_rdata          = 32'hDEAD_DEAD;
            e_err            = 1'b1;
         end
      end

      @(negedge clk);
      o_sreq = bus_a.s_req;  o_addr = bus_a.s_addr; o_ack = bus_a.m_ack;
      o_resp = bus_a.m_resp; o_rdata = bus_a.m_rdata; o_err = err_a; o_busy = busy_a;
      o_fack = bus_f.m_ack;
      chk("s_req", bus_a.s_req, e_sreq);
      if (e_sreq || !rst_n) begin
         chk("s_we", bus_a.s_we, e_we);
         chk("s_addr", bus_a.s_addr, e_addr);
         chk("s_be", bus_a.s_be, e_be);
         chk("s_wdata", bus_a.s_wdata, e_wdata);
      end
      chk("m_ack", bus_a.m_ack, e_ack);
      chk("m_resp", bus_a.m_resp, e_resp);
      chk("m_rdata", bus_a.m_rdata, e_rdata);
      chk("err", err_a, e_err);
      chk("busy", busy_a, e_busy);

      @(posedge clk);
      if (!rst_n) begin
         md_wait = 0; md_lock = 0; md_ptr = 0; md_owner = 0; md_cnt = 0; md_lockg = 0;
      end else if (!md_wait) begin
         if (e_sreq) begin
            if (bus_a.s_ack) begin
               md_lock = 0;
               md_ptr  = (e_g + 1) % N;
               if (!e_we) begin
                  md_wait = 1; md_owner = e_g; md_cnt = 0;
               end
            end else begin
               md_lock = 1; md_lockg = e_g;
            end
         end
      end else begin
         if (bus_a.s_resp || md_cnt == TMO) md_wait = 0;
         else md_cnt++;
      end
      #1;
   endtask

   initial begin
      logic [N-1:0] rr_exp [4];
      logic [N-1:0] ack_prev;
      rr_exp = '{2'b10, 2'b01, 2'b10, 2'b01};

      bus_a.m_req = '0; bus_a.m_we = '0; bus_a.m_addr = '0; bus_a.m_be = '0; bus_a.m_wdata = '0;
      bus_a.s_ack = 1'b0; bus_a.s_resp = 1'b0; bus_a.s_rdata = '0;
      bus_f.m_req = '0; bus_f.m_we = '0; bus_f.m_addr = '0; bus_f.m_be = '0; bus_f.m_wdata = '0;
      bus_f.s_ack = 1'b0; bus_f.s_resp = 1'b0; bus_f.s_rdata = '0;
      md_wait = 0; md_lock = 0; md_ptr = 0; md_owner = 0; md_cnt = 0; md_lockg = 0;

      // Reset holds every output low even with requests and acks present.
      step = "reset";
      @(posedge clk); #1;
      bus_a.m_req = 2'b11; bus_a.s_ack = 1'b1; bus_a.s_rdata = 32'h1234;
      tick();
      chk("rst_sreq", o_sreq, 1'b0);
      chk("rst_ack", o_ack, 2'b00);
      tick();
      rst_n = 1'b1; bus_a.m_req = '0; bus_a.s_rdata = '0;

      step = "write1";
      set_m(0, 1, 1, 32'h20, 4'hF, 32'h3);
      bus_a.s_ack = 1'b1;
      tick();
      chk("w1_sreq", o_sreq, 1'b1);
      chk("w1_ack", o_ack, 2'b01);
      chk("w1_addr", o_addr, 32'h20);
      chk("w1_resp", o_resp, 2'b00);

      // Round robin alternates; the fixed-priority copy always serves M0.
      step = "rr";
      bus_f.m_req = 2'b11; bus_f.m_we = 2'b11; bus_f.s_ack = 1'b1;
      for (int c = 0; c < 4; c++) begin
         set_m(0, 1, 1, 32'h100 + 32'(c), 4'h1, 32'(c));
         set_m(1, 1, 1, 32'h200 + 32'(c), 4'h2, 32'(c));
         tick();
         chk("rr_ack", o_ack, rr_exp[c]);
         chk("fx_ack", o_fack, 2'b01);
      end
      bus_f.m_req = '0;

      step = "read";
      set_m(0, 0, 0, 0, 0, 0);
      set_m(1, 1, 0, 32'h0, 4'hF, 0);
      tick();
      chk("rd_ack", o_ack, 2'b10);
      set_m(1, 0, 0, 0, 0, 0);
      set_m(0, 1, 1, 32'h44, 4'hF, 32'h77);
      bus_a.s_resp = 1'b1; bus_a.s_rdata = 32'hDEAD_BEEF;
      tick();
      chk("rd_resp", o_resp, 2'b10);
      chk("rd_rdata", o_rdata, 32'hDEAD_BEEF);
      chk("rd_m0_wait", o_ack, 2'b00);
      bus_a.s_resp = 1'b0;
      tick();
      chk("rd_m0_idle", o_ack, 2'b01);

      step = "lock";
      set_m(0, 0, 0, 0, 0, 0);
      set_m(1, 1, 1, 32'h80, 4'hF, 32'h8);
      tick();
      set_m(1, 1, 1, 32'h90, 4'hF, 32'h9);
      bus_a.s_ack = 1'b0;
      tick();
      set_m(0, 1, 1, 32'h10, 4'hF, 32'h1);
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("lk_addr", o_addr, 32'h90);
         chk("lk_ack", o_ack, 2'b00);
      end
      bus_a.s_ack = 1'b1;
      tick();
      chk("lk_ack1", o_ack, 2'b10);
      set_m(1, 0, 0, 0, 0, 0);
      tick();
      chk("lk_ack0", o_ack, 2'b01);
      set_m(0, 0, 0, 0, 0, 0);

      step = "timeout";
      set_m(0, 1, 0, 32'h30, 4'hF, 0);
      tick();
      set_m(0, 0, 0, 0, 0, 0);
      bus_a.s_ack = 1'b0;
      for (int w = 0; w <= TMO; w++) begin
         tick();
         chk("to_resp", o_resp, (w == TMO) ? 2'b01 : 2'b00);
         chk("to_err", o_err, (w == TMO) ? 1'b1 : 1'b0);
      end
      chk("to_rdata", o_rdata, 32'hDEAD_DEAD);
      bus_a.s_resp = 1'b1; bus_a.s_rdata = 32'h55;
      tick();
      chk("to_late", o_resp, 2'b00);
      bus_a.s_resp = 1'b0;

      step = "to_race";
      bus_a.s_ack = 1'b1;
      set_m(1, 1, 0, 32'h34, 4'hF, 0);
      tick();
      set_m(1, 0, 0, 0, 0, 0);
      bus_a.s_ack = 1'b0;
      for (int w = 0; w <= TMO; w++) begin
         if (w == TMO) begin
            bus_a.s_resp = 1'b1; bus_a.s_rdata = 32'h1234_5678;
         end
         tick();
      end
      chk("race_resp", o_resp, 2'b10);
      chk("race_rdata", o_rdata, 32'h1234_5678);
      chk("race_err", o_err, 1'b0);
      bus_a.s_resp = 1'b0;

      // Reset lands while M0's read is outstanding; afterwards M0 wins over M1 (pointer 0).
      step = "rst_mid";
      bus_a.s_ack = 1'b1;
      set_m(0, 1, 0, 32'h40, 4'hF, 0);
      tick();
      rst_n = 1'b0;
      tick();
      chk("rm_busy", o_busy, 1'b0);
      chk("rm_sreq", o_sreq, 1'b0);
      chk("rm_resp", o_resp, 2'b00);
      rst_n = 1'b1;
      set_m(0, 1, 0, 32'h50, 4'hF, 0);
      set_m(1, 1, 1, 32'h60, 4'hF, 32'h6);
      tick();
      chk("rm_ack", o_ack, 2'b01);
      chk("rm_addr", o_addr, 32'h50);
      set_m(0, 0, 0, 0, 0, 0);
      set_m(1, 0, 0, 0, 0, 0);
      bus_a.s_resp = 1'b1; bus_a.s_rdata = 32'hA5;
      tick();
      chk("rm_resp2", o_resp, 2'b01);
      bus_a.s_resp = 1'b0;

      // Random traffic: masters hold a request until acked, slave acks and answers at random.
      step = "random";
      ack_prev = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!bus_a.m_req[i] || ack_prev[i]) begin
               if ($urandom_range(0, 2) != 0)
                  set_m(i, 1, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom);
               else
                  bus_a.m_req[i] = 1'b0;
            end
         end
         bus_a.s_ack   = ($urandom_range(0, 3) != 0);
         bus_a.s_resp  = ($urandom_range(0, 4) == 0);
         bus_a.s_rdata = $urandom;
         tick();
         ack_prev = e_ack;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
